program_loader: RTL and testbench

- Writer side of the instruction memory: accepts a byte stream (length header + payload) over a valid/ready handshake and issues one write per payload byte into the 256x8 instruction RAM.
- instructionGetter reads that same RAM. The loader fills it before the processor is released from reset.
- Supports an explicit load base address through the same parallelFlag/parallelAddress pair the fetch side uses.

---
 rtl/loader_pkg.sv | 14 +
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
package loader_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        DONE
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake plus RAM write port between the loader and its neighbours.
// The slave side is the loader itself; the master side is the byte source / RAM.
interface program_loader_if;
    import loader_pkg::*;

    logic              byteValid;
    logic [DATA_W-1:0] byteIn;
    logic              byteReady;
    logic              wrEnable;
    logic [ADDR_W-1:0] wrAddress;
    logic [DATA_W-1:0] wrData;

    modport slave (
        input  byteValid,
        input  byteIn,
        output byteReady,
        output wrEnable,
        output wrAddress,
        output wrData
    );

    modport master (
        output byteValid,
        output byteIn,
        input  byteReady,
        input  wrEnable,
        input  wrAddress,
        input  wrData
    );

endinterface

// File: rtl/program_loader.sv
// Program loader: takes a length-prefixed byte stream and writes the payload
// into the 256x8 instruction RAM, one byte per cycle, starting at either 0 or
// an explicit base address. A header of 0 means a full 256-byte image.
module program_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_parallelFlag,
    input  logic [ADDR_W-1:0] i_parallelAddress,
    program_loader_if.slave   bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic [DATA_W-1:0] o_checksum
);

    loader_state_t     r_state;
    loader_state_t     w_nextState;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_wrEnable;
    logic [ADDR_W-1:0] r_wrAddress;
    logic [DATA_W-1:0] r_wrData;
    logic              r_overflow;
    logic [DATA_W-1:0] r_checksum;
    logic              w_byteReady;
    logic              w_transfer;
    logic              w_busy;
    logic              w_done;

    assign w_transfer    = bus.byteValid & w_byteReady;

    assign bus.byteReady = w_byteReady;
    assign bus.wrEnable  = r_wrEnable;
    assign bus.wrAddress = r_wrAddress;
    assign bus.wrData    = r_wrData;
    assign o_busy        = w_busy;
    assign o_done        = w_done;
    assign o_overflow    = r_overflow;
    assign o_checksum    = r_checksum;

    // State register; reset always returns to IDLE and abandons any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the state-derived handshake and status outputs.
    always_comb begin
        w_nextState = r_state;
        w_byteReady = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = HDR;
                end
            end
            HDR: begin
                w_byteReady = 1'b1;
                w_busy      = 1'b1;
                if (bus.byteValid) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                w_byteReady = 1'b1;
                w_busy      = 1'b1;
                if (bus.byteValid && (r_remaining == 9'd1)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: base latch, byte counter, registered RAM write port, checksum and wrap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_wrEnable  <= 1'b0;
            r_wrAddress <= '0;
            r_wrData    <= '0;
            r_overflow  <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_wrEnable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_ptr       <= i_parallelFlag ? i_parallelAddress : '0;
                        r_remaining <= '0;
                        r_overflow  <= 1'b0;
                        r_checksum  <= '0;
                    end
                end
                HDR: begin
                    if (w_transfer) begin
                        r_remaining <= (bus.byteIn == '0) ? 9'd256 : {1'b0, bus.byteIn};
                    end
                end
                DATA: begin
                    if (w_transfer) begin
                        r_wrEnable  <= 1'b1;
                        r_wrAddress <= r_ptr;
                        r_wrData    <= bus.byteIn;
                        r_ptr       <= r_ptr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        r_checksum  <= r_checksum ^ bus.byteIn;
                        if ((r_ptr == '1) && (r_remaining > 9'd1)) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a scoreboard of expected RAM writes is filled as
// payload bytes are driven and drained by a write monitor; a behavioural RAM
// and a simple fetch loop stand in for instructionGetter in the end-to-end test.
module tb_program_loader;
    import loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       parallelFlag = 1'b0;
    logic [7:0] parallelAddress = 8'h00;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [7:0] checksum;

    program_loader_if bus();

    program_loader dut (
        .clk               (clk),
        .rst               (rst),
        .i_start           (start),
        .i_parallelFlag    (parallelFlag),
        .i_parallelAddress (parallelAddress),
        .bus               (bus),
        .o_busy            (busy),
        .o_done            (done),
        .o_overflow        (overflow),
        .o_checksum        (checksum)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         last;
    } wr_t;

    wr_t        expQ[$];
    logic [7:0] payloadQ[$];
    logic [7:0] ram [256];
    int         vectors = 0;
    int         miscompares = 0;

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Behavioural instruction RAM written by the loader.
    always @(posedge clk) begin
        if (bus.wrEnable) begin
            ram[bus.wrAddress] <= bus.wrData;
        end
    end

    // Write monitor: every write must match the head of the scoreboard, and done
    // must coincide with the final write of a load and never appear elsewhere.
    always @(negedge clk) begin
        wr_t e;
        if (bus.wrEnable) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write: got addr %h data %h, required no write",
                         bus.wrAddress, bus.wrData);
            end else begin
                e = expQ.pop_front();
                if (bus.wrAddress !== e.addr || bus.wrData !== e.data || done !== e.last) begin
                    miscompares++;
                    $display("[TB] FAIL write: got addr %h data %h done %b, required addr %h data %h done %b",
                             bus.wrAddress, bus.wrData, done, e.addr, e.data, e.last);
                end
            end
        end else begin
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stray_done: got done %b without a write, required 0", done);
            end
        end
    end

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200us, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input bit pf, input logic [7:0] pa);
        start           = 1'b1;
        parallelFlag    = pf;
        parallelAddress = pa;
        tick();
        start           = 1'b0;
        parallelFlag    = ~pf;
        parallelAddress = ~pa;
    endtask

    task automatic sendByte(input logic [7:0] b, output bit ok);
        logic rdy;
        ok            = 1'b0;
        bus.byteValid = 1'b1;
        bus.byteIn    = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = bus.byteReady;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.byteValid = 1'b0;
    endtask

    task automatic runLoad(input bit pf, input logic [7:0] pa, input logic [7:0] hdr, output bit ok);
        logic [7:0] a;
        bit         k;
        a  = pf ? pa : 8'h00;
        ok = 1'b1;
        doStart(pf, pa);
        sendByte(hdr, k);
        ok &= k;
        for (int i = 0; i < payloadQ.size(); i++) begin
            expQ.push_back('{addr: a, data: payloadQ[i], last: (i == payloadQ.size() - 1)});
            sendByte(payloadQ[i], k);
            ok &= k;
            if (!k) break;
            a = a + 8'h01;
        end
    endtask

    task automatic test_reset();
        bus.byteValid = 1'b1;
        bus.byteIn    = 8'h5A;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.byteReady !== 1'b0 || bus.wrEnable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            overflow !== 1'b0 || bus.wrAddress !== 8'h00 || bus.wrData !== 8'h00 || checksum !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got rdy %b we %b busy %b done %b ovf %b addr %h data %h csum %h, required all 0",
                     bus.byteReady, bus.wrEnable, busy, done, overflow, bus.wrAddress, bus.wrData, checksum);
        end
        bus.byteValid = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        payloadQ = '{8'hA1, 8'hB2, 8'hC3};
        runLoad(1'b0, 8'h77, 8'h03, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL basic_handshake: got timeout, required acceptance");
        end
        tick();
        tick();
        vectors++;
        if (checksum !== 8'hD0 || overflow !== 1'b0 || busy !== 1'b0 || expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL basic_status: got csum %h ovf %b busy %b pending %0d, required D0 0 0 0",
                     checksum, overflow, busy, expQ.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        payloadQ = '{8'h11, 8'h22, 8'h33, 8'h44};
        runLoad(1'b1, 8'hFE, 8'h04, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL wrap_handshake: got timeout, required acceptance");
        end
        tick();
        tick();
        vectors++;
        if (checksum !== 8'h44 || overflow !== 1'b1 || expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL wrap_status: got csum %h ovf %b pending %0d, required 44 1 0",
                     checksum, overflow, expQ.size());
        end
    endtask

    task automatic test_full();
        bit ok;
        payloadQ.delete();
        for (int i = 0; i < 256; i++) payloadQ.push_back(i[7:0]);
        runLoad(1'b0, 8'h00, 8'h00, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL full_handshake: got timeout, required acceptance");
        end
        tick();
        tick();
        vectors++;
        if (checksum !== 8'h00 || overflow !== 1'b0 || expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL full_status: got csum %h ovf %b pending %0d, required 00 0 0",
                     checksum, overflow, expQ.size());
        end
    endtask

    task automatic test_gapped();
        bit         ok;
        logic [7:0] d [2];
        d[0] = 8'h9C;
        d[1] = 8'h3E;
        doStart(1'b1, 8'h40);
        sendByte(8'h02, ok);
        for (int k = 0; k < 2; k++) begin
            expQ.push_back('{addr: 8'h40 + k[7:0], data: d[k], last: (k == 1)});
            repeat (2) begin
                start = 1'b1;
                vectors++;
                if (bus.byteReady !== 1'b1 || bus.wrEnable !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL gap_idle: got rdy %b we %b busy %b, required 1 0 1",
                             bus.byteReady, bus.wrEnable, busy);
                end
                tick();
            end
            start = 1'b0;
            sendByte(d[k], ok);
            vectors++;
            if (!ok || bus.wrEnable !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL gap_latency: got we %b ok %b one cycle after accept, required 1 1",
                         bus.wrEnable, ok);
            end
            if (k == 0) tick();
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.byteReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL gap_done: got done %b busy %b rdy %b, required 1 0 0", done, busy, bus.byteReady);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || checksum !== (8'h9C ^ 8'h3E) || expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL gap_after: got busy %b csum %h pending %0d, required 0 %h 0",
                     busy, checksum, expQ.size(), 8'h9C ^ 8'h3E);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        doStart(1'b0, 8'h00);
        sendByte(8'h05, ok);
        expQ.push_back('{addr: 8'h00, data: 8'h5A, last: 1'b0});
        sendByte(8'h5A, ok);
        expQ.push_back('{addr: 8'h01, data: 8'h6B, last: 1'b0});
        sendByte(8'h6B, ok);
        bus.byteValid = 1'b1;
        bus.byteIn    = 8'h77;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        bus.byteValid = 1'b0;
        vectors++;
        if (bus.byteReady !== 1'b0 || bus.wrEnable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            overflow !== 1'b0 || bus.wrAddress !== 8'h00 || bus.wrData !== 8'h00 || checksum !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midreset_state: got rdy %b we %b busy %b done %b ovf %b addr %h data %h csum %h, required all 0",
                     bus.byteReady, bus.wrEnable, busy, done, overflow, bus.wrAddress, bus.wrData, checksum);
        end
        bus.byteValid = 1'b1;
        bus.byteIn    = 8'h12;
        repeat (4) begin
            tick();
            vectors++;
            if (bus.byteReady !== 1'b0 || busy !== 1'b0 || expQ.size() != 0) begin
                miscompares++;
                $display("[TB] FAIL midreset_idle: got rdy %b busy %b pending %0d, required 0 0 0",
                         bus.byteReady, busy, expQ.size());
            end
        end
        bus.byteValid = 1'b0;
        payloadQ = '{8'h01, 8'h02, 8'h04};
        runLoad(1'b0, 8'hC0, 8'h03, ok);
        tick();
        tick();
        vectors++;
        if (!ok || checksum !== 8'h07 || expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_reload: got ok %b csum %h pending %0d, required 1 07 0",
                     ok, checksum, expQ.size());
        end
    endtask

    task automatic test_end_to_end();
        bit         ok;
        logic [7:0] instr;
        payloadQ = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        runLoad(1'b0, 8'h00, 8'h05, ok);
        tick();
        tick();
        for (int pc = 0; pc < 5; pc++) begin
            instr = ram[pc];
            tick();
            vectors++;
            if (instr !== 8'h10 * (pc[7:0] + 8'h01)) begin
                miscompares++;
                $display("[TB] FAIL fetch_%0d: got %h, required %h", pc, instr, 8'h10 * (pc[7:0] + 8'h01));
            end
        end
    endtask

    // Test sequence.
    initial begin
        bus.byteValid = 1'b0;
        bus.byteIn    = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_gapped();
        test_reset_mid();
        test_end_to_end();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
